// File: rtl/serializer_if.sv
// Producer-side and link-side handshake signals of the serializer.
interface serializer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  write_in;
  logic                  status_out;
  logic                  data_out;
  logic                  write_out;
  logic                  status_in;

  // Serializer view: takes words and receiver status, drives the serial strobe.
  modport slave (
    input  data_in, write_in, status_in,
    output status_out, data_out, write_out
  );

  // Environment view: producer plus receiver.
  modport master (
    output data_in, write_in, status_in,
    input  status_out, data_out, write_out
  );
endinterface

// File: rtl/serializer.sv
// Parallel-to-serial transmitter, MSB first, with a one-word holding register
// so the producer can queue the next word while the current one shifts out.
module serializer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic        clk_100mhz,
  input  logic        reset_n,
  serializer_if.slave bus,
  output logic        busy,
  output logic        byte_done
);

  localparam int unsigned CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned LAST_BIT = DATA_WIDTH - 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic [GAP_W-1:0]      gap_cnt_q;
  logic                  last_sent_q;
  logic                  status_q;
  logic                  data_q;
  logic                  write_q;
  logic                  busy_q;
  logic                  done_q;

  logic hold_valid_c;
  logic last_bit_c;
  logic intake_c;

  // Hold register is full exactly when status_out is low.
  assign hold_valid_c = ~status_q;
  // bit_cnt never advances past the last bit; it returns to 0 only on reload.
  assign last_bit_c   = (bit_cnt_q == CNT_W'(LAST_BIT));
  assign intake_c     = bus.write_in & status_q;

  // Intake, shift FSM and all registered outputs.
  always_ff @(posedge clk_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      last_sent_q <= 1'b0;
      status_q    <= 1'b1;
      data_q      <= 1'b0;
      write_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      write_q <= 1'b0;
      done_q  <= 1'b0;

      // Intake and reload are exclusive: intake needs an empty hold, reload a full one.
      if (intake_c) begin
        hold_q   <= bus.data_in;
        status_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (hold_valid_c) begin
            shift_q   <= hold_q;
            status_q  <= 1'b1;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (bus.status_in) begin
            data_q  <= shift_q[DATA_WIDTH-1];
            write_q <= 1'b1;
            shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
            if (last_bit_c) begin
              done_q <= 1'b1;
              if (GAP_CYCLES > 0) begin
                gap_cnt_q   <= '0;
                last_sent_q <= 1'b1;
                state_q     <= ST_GAP;
              end else if (hold_valid_c) begin
                shift_q   <= hold_q;
                status_q  <= 1'b1;
                bit_cnt_q <= '0;
              end else begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
              if (GAP_CYCLES > 0) begin
                gap_cnt_q <= '0;
                state_q   <= ST_GAP;
              end
            end
          end
        end

        ST_GAP: begin
          if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
            last_sent_q <= 1'b0;
            if (!last_sent_q) begin
              state_q <= ST_SEND;
            end else if (hold_valid_c) begin
              shift_q   <= hold_q;
              status_q  <= 1'b1;
              bit_cnt_q <= '0;
              state_q   <= ST_SEND;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.status_out = status_q;
  assign bus.data_out   = data_q;
  assign bus.write_out  = write_q;
  assign busy           = busy_q;
  assign byte_done      = done_q;

endmodule
